// File: rtl/ssr_pkg.sv
// ssr_pkg
//   Constants shared by the SSR transponder stage and the reply decoder.
//   All time constants are in clk ticks (20 MHz, 0.05 us per tick).
//   Contents: pulse/slot timing, slot-counter compare values, FSM state
//   encoding, and the bit position of each reply slot inside the decoder's
//   13-bit slot shift register.
package ssr_pkg;

    localparam int L       = 9;        // pulse width
    localparam int BL      = 20;       // blank between pulses
    localparam int P       = L + BL;   // slot period
    localparam int MID     = 4;        // sample offset into a slot
    localparam int GAP     = 19;       // gap-check offset into a slot
    localparam int N_SLOTS = 14;       // F1 is slot 0, F2 is slot 14
    localparam int X_SLOT  = 7;
    localparam int SR_W    = 13;       // code slots 1..13

    localparam logic [4:0] S_MID  = 5'(MID);
    localparam logic [4:0] S_GAP  = 5'(GAP);
    localparam logic [4:0] S_LAST = 5'(P - 1);
    localparam logic [3:0] N_LAST_CODE = 4'(N_SLOTS - 1);
    localparam logic [4:0] WL_LOAD = 5'(BL - 1);

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_F1       = 3'd1;
    localparam logic [2:0] ENC_SLOTS    = 3'd2;
    localparam logic [2:0] ENC_F2       = 3'd3;
    localparam logic [2:0] ENC_WAIT_LOW = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ENC_IDLE,
        F1       = ENC_F1,
        SLOTS    = ENC_SLOTS,
        F2       = ENC_F2,
        WAIT_LOW = ENC_WAIT_LOW
    } state_t;

    // Slots are shifted in LSB-first order, so after 13 shifts slot n sits
    // at bit SR_W-n (slot 1 ends up in the MSB).
    function automatic int slot_idx(input int n);
        return SR_W - n;
    endfunction

    localparam int IDX_C1 = slot_idx(1);
    localparam int IDX_A1 = slot_idx(2);
    localparam int IDX_C2 = slot_idx(3);
    localparam int IDX_A2 = slot_idx(4);
    localparam int IDX_C4 = slot_idx(5);
    localparam int IDX_A4 = slot_idx(6);
    localparam int IDX_X  = slot_idx(X_SLOT);
    localparam int IDX_B1 = slot_idx(8);
    localparam int IDX_D1 = slot_idx(9);
    localparam int IDX_B2 = slot_idx(10);
    localparam int IDX_D2 = slot_idx(11);
    localparam int IDX_B4 = slot_idx(12);
    localparam int IDX_D4 = slot_idx(13);

endpackage

// File: rtl/ssr_slot_timer.sv
// ssr_slot_timer
//   Phase (s, 0..P-1) and slot (n) counters for the reply decoder.
//   Ports:
//     clk, rst      clock, async active-high reset
//     start         load s=1, n=0 (the rise cycle itself counts as s=0)
//     run           advance the counters; when neither start nor run, clear
//     n             current slot number
//     at_mid        s == MID while running
//     at_gap        s == GAP while running
//     slot_end      s == P-1 while running (next cycle starts a new slot)
module ssr_slot_timer
    import ssr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    output logic [3:0] n,
    output logic       at_mid,
    output logic       at_gap,
    output logic       slot_end
);

    logic [4:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            n <= '0;
        end else if (start) begin
            s <= 5'd1;
            n <= '0;
        end else if (run) begin
            if (s == S_LAST) begin
                s <= '0;
                n <= n + 4'd1;
            end else begin
                s <= s + 5'd1;
            end
        end else begin
            s <= '0;
            n <= '0;
        end
    end

    assign at_mid   = run && (s == S_MID);
    assign at_gap   = run && (s == S_GAP);
    assign slot_end = run && (s == S_LAST);

endmodule

// File: rtl/ssr_reply_decoder.sv
// ssr_reply_decoder
//   Frames a Mode A/C reply pulse train on F1/F2, extracts the A/B/C/D code
//   bits and X, and reports one valid or frame_err pulse per reply.
//   Ports:
//     clk, rst           clock, async active-high reset
//     rx                 reply video, synchronous to clk
//     code_a..code_d     3-bit codes (bit0 = weight 1), held until next valid
//     x_bit              X bit of the last valid reply
//     valid              1-cycle pulse, outputs updated on the same cycle
//     frame_err          1-cycle pulse, reply rejected
//     busy               FSM not in IDLE
//     reply_cnt          count of valid pulses, wraps
//
//   state    | meaning
//   IDLE     | waiting for a rising edge on rx_q
//   F1       | slot 0: confirm F1 is a real pulse at MID
//   SLOTS    | slots 1..13: sample code bits at MID, check blank at GAP
//   F2       | slot 14: F2 must be present at MID
//   WAIT_LOW | reply accepted, waiting for F2 to end (max BL ticks)
module ssr_reply_decoder
    import ssr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [2:0]  code_a,
    output logic [2:0]  code_b,
    output logic [2:0]  code_c,
    output logic [2:0]  code_d,
    output logic        x_bit,
    output logic        valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] reply_cnt
);

    logic rx_q, rx_d, rise;
    state_t state, state_nxt;

    logic [3:0] n;
    logic at_mid, at_gap, slot_end;
    logic timer_start, timer_run;

    logic [SR_W-1:0] sr;
    logic [4:0] wl_cnt;

    logic shift_en, load_en, err_nxt, wl_load, wl_dec;

    assign rise = rx_q & ~rx_d;

    ssr_slot_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (timer_start),
        .run      (timer_run),
        .n        (n),
        .at_mid   (at_mid),
        .at_gap   (at_gap),
        .slot_end (slot_end)
    );

    assign timer_run = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        timer_start = 1'b0;
        shift_en    = 1'b0;
        load_en     = 1'b0;
        err_nxt     = 1'b0;
        wl_load     = 1'b0;
        wl_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt   = F1;
                    timer_start = 1'b1;
                end
            end
            F1: begin
                if (at_mid && !rx_q) begin
                    state_nxt = IDLE;
                end else if (slot_end) begin
                    state_nxt = SLOTS;
                end
            end
            SLOTS: begin
                shift_en = at_mid;
                if (at_gap && rx_q) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (slot_end && (n == N_LAST_CODE)) begin
                    state_nxt = F2;
                end
            end
            F2: begin
                if (at_mid) begin
                    if (rx_q) begin
                        load_en   = 1'b1;
                        wl_load   = 1'b1;
                        state_nxt = WAIT_LOW;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_LOW: begin
                if (!rx_q) begin
                    state_nxt = IDLE;
                end else if (wl_cnt == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wl_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q      <= 1'b0;
            rx_d      <= 1'b0;
            state     <= IDLE;
            sr        <= '0;
            wl_cnt    <= '0;
            code_a    <= '0;
            code_b    <= '0;
            code_c    <= '0;
            code_d    <= '0;
            x_bit     <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            reply_cnt <= '0;
        end else begin
            rx_q      <= rx;
            rx_d      <= rx_q;
            state     <= state_nxt;
            valid     <= load_en;
            frame_err <= err_nxt;
            if (shift_en) begin
                sr <= {sr[SR_W-2:0], rx_q};
            end
            if (wl_load) begin
                wl_cnt <= WL_LOAD;
            end else if (wl_dec) begin
                wl_cnt <= wl_cnt - 5'd1;
            end
            if (load_en) begin
                code_a    <= {sr[IDX_A4], sr[IDX_A2], sr[IDX_A1]};
                code_b    <= {sr[IDX_B4], sr[IDX_B2], sr[IDX_B1]};
                code_c    <= {sr[IDX_C4], sr[IDX_C2], sr[IDX_C1]};
                code_d    <= {sr[IDX_D4], sr[IDX_D2], sr[IDX_D1]};
                x_bit     <= sr[IDX_X];
                reply_cnt <= reply_cnt + 16'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
